// File: rtl/pc_fetch_sequencer.sv
// Program-counter controller: sequences req/ack instruction fetches and applies redirects.
// Optional 4-entry return stack enabled by defining PC_CALL_STACK_EN.
`timescale 1ns/1ps
module pc_fetch_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  input  logic        call,
  input  logic        ret,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic        stack_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        redir;
  logic [15:0] target;
  logic        pending;
  logic [15:0] pend_addr;

`ifdef PC_CALL_STACK_EN
  logic [15:0] stk [4];
  logic [1:0]  sp;
  logic [1:0]  sp_top;
  logic [2:0]  cnt;
  logic        do_push;
  logic        do_pop;

  assign sp_top = sp - 2'd1;

  // ret outranks call, which outranks jump; an empty pop redirects to 0.
  always_comb begin
    redir   = 1'b0;
    target  = jump_addr;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (ret) begin
      redir  = 1'b1;
      do_pop = 1'b1;
      target = (cnt == 3'd0) ? '0 : stk[sp_top];
    end else if (call || jump) begin
      redir   = 1'b1;
      do_push = call;
    end
  end

  // Circular storage: a push when full lands on the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) stk[i] <= '0;
      sp        <= '0;
      cnt       <= '0;
      stack_err <= 1'b0;
    end else if (do_push) begin
      stk[sp] <= pc;
      sp      <= sp + 2'd1;
      if (cnt == 3'd4) stack_err <= 1'b1;
      else             cnt       <= cnt + 3'd1;
    end else if (do_pop) begin
      if (cnt == 3'd0) begin
        stack_err <= 1'b1;
      end else begin
        sp  <= sp_top;
        cnt <= cnt - 3'd1;
      end
    end
  end
`else
  logic unused_ret;

  assign unused_ret = ret;
  assign stack_err  = 1'b0;

  always_comb begin
    redir  = call || jump;
    target = jump_addr;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!halt) state_next = REQ;
      REQ:     if (fetch_ack) state_next = DONE;
      DONE:    state_next = halt ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_req  = (state == REQ);
    fetch_addr = pc;
  end

  // A redirect during REQ is parked until the ack, so the in-flight data is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pending     <= 1'b0;
      pend_addr   <= '0;
    end else begin
      instr_valid <= 1'b0;
      if (state == REQ) begin
        if (fetch_ack) begin
          pending <= 1'b0;
          if (redir) begin
            pc <= target;
          end else if (pending) begin
            pc <= pend_addr;
          end else begin
            instr       <= fetch_data;
            instr_valid <= 1'b1;
            pc          <= pc + 16'd1;
          end
        end else if (redir) begin
          pending   <= 1'b1;
          pend_addr <= target;
        end
      end else if (redir) begin
        pc <= target;
      end
    end
  end

endmodule
